// File: rtl/param_reg_file_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Imported by the interface, the read-port sub-module and the top.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int ZERO_REG   = 0;

    // Bit offset of lane `lane` inside a packed vector of `width`-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// Decode/writeback-side bus of the register file.
// master = pipeline side; slave = register file.
interface param_reg_file_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) ();

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     flush;
    logic                     busy_any;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_any
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_any
    );

endinterface

// File: rtl/param_reg_file_read_port.sv
// One asynchronous read port: zero-register detect, optional write bypass,
// and data/busy selection from the registered state.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = 1 << DEF_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] regs [NREGS],
    input  logic [NREGS-1:0]  busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              busy_out
);

    logic is_zero;
    logic hit;

    assign is_zero = (addr == ADDR_W'(ZERO_REG));
    assign hit     = BYPASS && wr_en && (wr_addr == addr);

    // NOTE: every output gets a default at the top of always_comb so no path
    // through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        data     = regs[addr];
        busy_out = busy[addr];
        if (is_zero) begin
            data     = '0;
            busy_out = 1'b0;
        end else if (hit) begin
            // The writeback completing now retires the producer as well.
            data     = wr_data;
            busy_out = 1'b0;
        end
    end

endmodule

// File: rtl/param_reg_file.sv
// General-purpose register file with hardwired zero register, optional
// write-to-read bypass and a per-register busy scoreboard for RAW detection.
module param_reg_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter bit BYPASS = 1'b1
) (
    input logic              clk,
    input logic              reset,
    param_reg_file_if.slave  bus
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem       [1:NREGS-1];
    logic [DATA_W-1:0] regs_view [NREGS];
    logic [NREGS-1:1]  busy_q;
    logic [NREGS-1:1]  busy_nxt;
    logic [NREGS-1:0]  busy_view;
    logic [DATA_W-1:0] lane_data [NUM_RD];
    logic [NUM_RD-1:0] lane_busy;

    // NOTE: the storage array is reset entry by entry because every register
    // must read zero after reset; that costs a reset leg on each flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.wr_en && bus.wr_addr != ADDR_W'(ZERO_REG)) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Flush beats issue; issue beats a same-cycle writeback to that register.
    always_comb begin
        busy_nxt = busy_q;
        if (bus.flush) begin
            busy_nxt = '0;
        end else begin
            for (int a = 1; a < NREGS; a++) begin
                if (bus.iss_en && bus.iss_addr == ADDR_W'(a)) begin
                    busy_nxt[a] = 1'b1;
                end else if (bus.wr_en && bus.wr_addr == ADDR_W'(a)) begin
                    busy_nxt[a] = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    always_comb begin
        regs_view[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            regs_view[i] = mem[i];
        end
    end

    assign busy_view    = {busy_q, 1'b0};
    assign bus.busy_any = |busy_q;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NREGS  (NREGS),
            .BYPASS (BYPASS)
        ) u_port (
            .addr     (bus.rd_addr[lane_lsb(p, ADDR_W) +: ADDR_W]),
            .regs     (regs_view),
            .busy     (busy_view),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .data     (lane_data[p]),
            .busy_out (lane_busy[p])
        );
    end

    always_comb begin
        bus.rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            bus.rd_data[lane_lsb(p, DATA_W) +: DATA_W] = lane_data[p];
        end
    end

    assign bus.rd_busy = lane_busy;

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench: identical stimulus drives a BYPASS=1 and a BYPASS=0 instance;
// expected read results are queued per cycle and checked by a separate monitor.
module tb_param_reg_file;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    param_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_b ();
    param_reg_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_n ();

    param_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    param_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n)
    );

    typedef struct {
        int          cyc;
        int          dut;   // 0 = bypass instance, 1 = no-bypass instance
        int          port;
        logic [31:0] data;
        logic        busy;
        logic        any;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cycle  = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    task automatic drive(input logic [4:0] r0, input logic [4:0] r1,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ia, input logic fl);
        bus_b.rd_addr = {r1, r0};  bus_n.rd_addr = {r1, r0};
        bus_b.wr_en   = we;        bus_n.wr_en   = we;
        bus_b.wr_addr = wa;        bus_n.wr_addr = wa;
        bus_b.wr_data = wd;        bus_n.wr_data = wd;
        bus_b.iss_en  = ie;        bus_n.iss_en  = ie;
        bus_b.iss_addr = ia;       bus_n.iss_addr = ia;
        bus_b.flush   = fl;        bus_n.flush   = fl;
    endtask

    task automatic idle_rd(input logic [4:0] r0, input logic [4:0] r1);
        drive(r0, r1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic exp1(input int dut, input int port, input logic [31:0] d,
                        input logic b, input logic any, input string name);
        exp_t e;
        e.cyc = cycle; e.dut = dut; e.port = port;
        e.data = d; e.busy = b; e.any = any; e.name = name;
        sb.push_back(e);
    endtask

    task automatic exp2(input int port, input logic [31:0] d,
                        input logic b, input logic any, input string name);
        exp1(0, port, d, b, any, name);
        exp1(1, port, d, b, any, name);
    endtask

    task automatic check(input exp_t e);
        logic [31:0] d;
        logic        b;
        logic        a;
        if (e.dut == 0) begin
            d = bus_b.rd_data[e.port*DW +: DW];
            b = bus_b.rd_busy[e.port];
            a = bus_b.busy_any;
        end else begin
            d = bus_n.rd_data[e.port*DW +: DW];
            b = bus_n.rd_busy[e.port];
            a = bus_n.busy_any;
        end
        n_cmp++;
        if (e.cyc != cycle || d !== e.data || b !== e.busy || a !== e.any) begin
            n_bad++;
            $display("FAIL %s (%s port %0d cyc %0d/%0d): got data=%h busy=%b any=%b, want data=%h busy=%b any=%b",
                     e.name, (e.dut == 0) ? "bypass" : "nobypass", e.port, e.cyc, cycle,
                     d, b, a, e.data, e.busy, e.any);
        end
    endtask

    // Monitor: compares whatever the stimulus queued for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cycle) begin
                e = sb.pop_front();
                check(e);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_rd(5'd0, 5'd0);
        step();
        step();
        reset = 1'b0;

        // Post-reset sweep of every address on both ports.
        for (int a = 0; a < 32; a++) begin
            idle_rd(5'(a), 5'(31 - a));
            exp2(0, 32'h0, 1'b0, 1'b0, "reset_sweep_p0");
            exp2(1, 32'h0, 1'b0, 1'b0, "reset_sweep_p1");
            step();
        end

        // Same-cycle write/read of reg 5.
        drive(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        exp1(0, 0, 32'hDEADBEEF, 1'b0, 1'b0, "wr5_bypass");
        exp1(1, 0, 32'h0,        1'b0, 1'b0, "wr5_nobypass");
        exp2(1, 32'h0, 1'b0, 1'b0, "wr5_p1_r0");
        step();
        idle_rd(5'd5, 5'd0);
        exp2(0, 32'hDEADBEEF, 1'b0, 1'b0, "wr5_next");
        step();

        // Register 0 ignores writes and issues.
        drive(5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0);
        exp2(0, 32'h0, 1'b0, 1'b0, "wr0_same");
        step();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        exp2(0, 32'h0, 1'b0, 1'b0, "iss0_same");
        step();
        idle_rd(5'd0, 5'd5);
        exp2(0, 32'h0, 1'b0, 1'b0, "r0_after");
        exp2(1, 32'hDEADBEEF, 1'b0, 1'b0, "r5_hold");
        step();

        // Reg 7: issue, WAW with same-cycle writeback, final writeback.
        drive(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
        exp2(0, 32'h0, 1'b0, 1'b0, "r7_c1");
        step();
        idle_rd(5'd7, 5'd0);
        exp2(0, 32'h0, 1'b1, 1'b1, "r7_c2");
        step();
        idle_rd(5'd7, 5'd0);
        exp2(0, 32'h0, 1'b1, 1'b1, "r7_c3");
        step();
        drive(5'd7, 5'd0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 1'b0);
        exp1(0, 0, 32'h77, 1'b0, 1'b1, "r7_c4_bypass");
        exp1(1, 0, 32'h0,  1'b1, 1'b1, "r7_c4_nobypass");
        step();
        idle_rd(5'd7, 5'd0);
        exp2(0, 32'h77, 1'b1, 1'b1, "r7_c5");
        step();
        drive(5'd7, 5'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0, 1'b0);
        exp1(0, 0, 32'h78, 1'b0, 1'b1, "r7_c6_bypass");
        exp1(1, 0, 32'h77, 1'b1, 1'b1, "r7_c6_nobypass");
        step();
        idle_rd(5'd7, 5'd0);
        exp2(0, 32'h78, 1'b0, 1'b0, "r7_c7");
        step();

        // Issue 3, 9, 12 then flush with a concurrent issue and writeback.
        drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        exp2(0, 32'h0, 1'b0, 1'b0, "iss3");
        step();
        drive(5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        exp2(0, 32'h0, 1'b1, 1'b1, "busy3");
        step();
        drive(5'd9, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0);
        exp2(0, 32'h0, 1'b1, 1'b1, "busy9");
        exp2(1, 32'h0, 1'b1, 1'b1, "busy3_p1");
        step();
        drive(5'd12, 5'd3, 1'b1, 5'd3, 32'h55, 1'b1, 5'd4, 1'b1);
        exp2(0, 32'h0, 1'b1, 1'b1, "flush_r12");
        exp1(0, 1, 32'h55, 1'b0, 1'b1, "flush_r3_bypass");
        exp1(1, 1, 32'h0,  1'b1, 1'b1, "flush_r3_nobypass");
        step();
        idle_rd(5'd3, 5'd4);
        exp2(0, 32'h55, 1'b0, 1'b0, "post_flush_r3");
        exp2(1, 32'h0,  1'b0, 1'b0, "post_flush_r4");
        step();
        idle_rd(5'd9, 5'd12);
        exp2(0, 32'h0, 1'b0, 1'b0, "post_flush_r9");
        exp2(1, 32'h0, 1'b0, 1'b0, "post_flush_r12");
        step();

        // Reset mid-operation overrides a same-cycle write and issue.
        drive(5'd0, 5'd0, 1'b1, 5'd10, 32'hA5A5A5A5, 1'b1, 5'd13, 1'b0);
        exp2(0, 32'h0, 1'b0, 1'b0, "wr10");
        step();
        idle_rd(5'd10, 5'd13);
        exp2(0, 32'hA5A5A5A5, 1'b0, 1'b1, "r10_before_reset");
        exp2(1, 32'h0,        1'b1, 1'b1, "r13_busy");
        step();
        reset = 1'b1;
        drive(5'd13, 5'd0, 1'b1, 5'd10, 32'h1, 1'b1, 5'd11, 1'b0);
        exp2(0, 32'h0, 1'b1, 1'b1, "reset_cycle_r13");
        exp2(1, 32'h0, 1'b0, 1'b1, "reset_cycle_r0");
        step();
        reset = 1'b0;
        idle_rd(5'd10, 5'd13);
        exp2(0, 32'h0, 1'b0, 1'b0, "post_reset_r10");
        exp2(1, 32'h0, 1'b0, 1'b0, "post_reset_r13");
        step();
        idle_rd(5'd5, 5'd11);
        exp2(0, 32'h0, 1'b0, 1'b0, "post_reset_r5");
        exp2(1, 32'h0, 1'b0, 1'b0, "post_reset_r11");
        step();
        idle_rd(5'd7, 5'd3);
        exp2(0, 32'h0, 1'b0, 1'b0, "post_reset_r7");
        exp2(1, 32'h0, 1'b0, 1'b0, "post_reset_r3");
        step();

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
            n_bad += sb.size();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_reg_file.md
# param_reg_file

Parametrised general-purpose register file for the CPU datapath: 2^ADDR_W registers of DATA_W bits, NUM_RD asynchronous read ports, one synchronous write port, hardwired zero register, and optional write-to-read bypass. A per-register busy scoreboard tracks in-flight destination registers between issue and writeback, so decode can detect RAW hazards without external bookkeeping. It sits between decode (read ports, issue) and writeback (write port).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; register count NREGS = 2^ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port p source register has an outstanding producer
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  instruction with destination issued this cycle
- iss_addr  in  ADDR_W  issued destination register
- flush  in  1  pipeline squash: clear all busy bits
- busy_any  out  1  OR of all busy bits (registered state only)

## Operation
- Storage: regs[1..NREGS-1] flops; register 0 reads DATA_W'0 always, never stored, never busy.
- Write: on edge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data. wr_addr=0 ignored.
- Scoreboard busy[1..NREGS-1], next-state per register a (a!=0), priority top-down:
  - reset: 0
  - flush: 0 (iss_en ignored that cycle; write data still committed)
  - iss_en && iss_addr==a: 1 (new producer wins over same-cycle writeback to a)
  - wr_en && wr_addr==a: 0
  - else hold
- Read port p, address a: a==0 -> data 0, busy 0. Else if BYPASS && wr_en && wr_addr==a -> data wr_data, busy 0. Else data regs[a], busy busy[a].
- With BYPASS=0, reading a being written in the same cycle returns old value and old busy.
- Writeback to a non-busy register is legal: data written, busy stays 0.
- Iss_en to a busy register (WAW) is legal: busy stays 1; first writeback clears it.

## Timing
- Reads purely combinational from rd_addr/wr_* to rd_data/rd_busy; zero latency.
- Write latency 1 cycle (visible on registered path next cycle; same cycle with BYPASS=1).
- Busy set visible on rd_busy the cycle after iss_en; cleared the cycle after wr_en (same cycle via bypass when BYPASS=1).
- After reset: all regs 0, all busy 0, busy_any 0, rd_data 0 for every address.
- Reset asserted mid-operation overrides wr_en, iss_en, flush in that cycle.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W constants, ZERO_REG = 0 constant, lane slice helper function for packed port vectors.
- One sub-module rf_read_port (zero detect, bypass compare, data/busy mux), generated NUM_RD times; storage and scoreboard stay in top.

## Test plan
- Reset, then read all 32 addresses on both ports -> rd_data 0, rd_busy 0, busy_any 0.
- wr_en, wr_addr=5, wr_data=0xDEADBEEF; same cycle rd_addr0=5 -> BYPASS=1 returns 0xDEADBEEF; BYPASS=0 returns 0, then 0xDEADBEEF next cycle.
- wr_addr=0, wr_data=0x12345678; then iss_addr=0 -> reads of reg 0 stay 0, rd_busy 0, busy_any 0.
- iss_addr=7 cycle 1 -> rd_busy for 7 is 1 from cycle 2; wr_addr=7 and iss_addr=7 in cycle 4 -> busy stays 1, data updated; wr_addr=7 cycle 6 -> busy 0.
- iss to regs 3,9,12 then flush together with iss_addr=4 and wr_addr=3 data 0x55 -> all busy 0, busy_any 0, reg3 reads 0x55.
- Write reg 10 = 0xA5A5A5A5, assert reset together with wr_addr=10 data 0x1 -> next cycle reg 10 reads 0.
